// File: rtl/pipe_shifter_if.sv
// Handshake bundle for pipe_shifter: operation request on in_*, result and
// occupancy on out_* / in_flight.
interface pipe_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_amt;
    logic [2:0]       in_op;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAGW-1:0]  out_tag;
    logic [SW:0]      in_flight;

    modport master (
        output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, in_flight
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, in_flight
    );
endinterface

// File: rtl/pipe_shifter.sv
// Log-depth pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR/pass) with a
// single global advance and valid/ready handshakes on both sides.
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic          clock,
    input  logic          reset,
    pipe_shifter_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_data [SW];
    logic [SW-1:0]    r_amt  [SW];
    logic [2:0]       r_op   [SW];
    logic [TAGW-1:0]  r_tag  [SW];
    logic [SW-1:0]    r_valid;
    logic [SW:0]      r_in_flight;
    logic [SW:0]      w_flight_nxt;
    logic             w_advance;

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                 input logic [2:0]       op,
                                                 input int               sh);
        logic [WIDTH-1:0] res;
        case (op)
            3'b000:  res = d << sh;
            3'b001:  res = d >> sh;
            // sign bit never moves in an arithmetic shift, so staging keeps the original MSB
            3'b010:  res = $unsigned($signed(d) >>> sh);
            3'b011:  res = (d << sh) | (d >> (WIDTH - sh));
            3'b100:  res = (d >> sh) | (d << (WIDTH - sh));
            default: res = d;
        endcase
        return res;
    endfunction

    assign w_advance     = !r_valid[SW-1] || bus.out_ready;
    assign bus.in_ready  = w_advance && !reset;
    assign bus.out_valid = r_valid[SW-1];
    assign bus.out_data  = r_data[SW-1];
    assign bus.out_tag   = r_tag[SW-1];
    assign bus.in_flight = r_in_flight;

    // Stage registers: stage k applies the 2^(SW-1-k) step selected by its amount bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SW; k++) begin
                r_data[k] <= {WIDTH{1'b0}};
                r_amt[k]  <= {SW{1'b0}};
                r_op[k]   <= 3'b000;
                r_tag[k]  <= {TAGW{1'b0}};
            end
            r_valid <= {SW{1'b0}};
        end else if (w_advance) begin
            r_data[0]  <= bus.in_amt[SW-1] ?
                          f_shift(bus.in_data, bus.in_op, 32'd1 << (SW - 1)) : bus.in_data;
            r_amt[0]   <= bus.in_amt;
            r_op[0]    <= bus.in_op;
            r_tag[0]   <= bus.in_tag;
            r_valid[0] <= bus.in_valid;
            for (int k = 1; k < SW; k++) begin
                r_data[k]  <= r_amt[k-1][SW-1-k] ?
                              f_shift(r_data[k-1], r_op[k-1], 32'd1 << (SW - 1 - k)) : r_data[k-1];
                r_amt[k]   <= r_amt[k-1];
                r_op[k]    <= r_op[k-1];
                r_tag[k]   <= r_tag[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Occupancy after the coming edge: incoming valid plus the valids that shift down.
    always_comb begin
        w_flight_nxt = r_in_flight;
        if (w_advance) begin
            w_flight_nxt = {{SW{1'b0}}, bus.in_valid};
            for (int k = 0; k < SW - 1; k++) begin
                w_flight_nxt = w_flight_nxt + {{SW{1'b0}}, r_valid[k]};
            end
        end else begin
            w_flight_nxt = r_in_flight;
        end
    end

    // Registered occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_flight <= {(SW + 1){1'b0}};
        end else begin
            r_in_flight <= w_flight_nxt;
        end
    end
endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: directed cases on a 32-bit instance, random traffic
// with random backpressure on an 8-bit instance, both against a queue model.
module tb_pipe_shifter;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    pipe_shifter_if #(.WIDTH(32), .TAGW(4)) b32();
    pipe_shifter_if #(.WIDTH(8),  .TAGW(2)) b8();

    pipe_shifter #(.WIDTH(32), .TAGW(4)) dut32 (.clock(clock), .reset(reset), .bus(b32));
    pipe_shifter #(.WIDTH(8),  .TAGW(2)) dut8  (.clock(clock), .reset(reset), .bus(b8));

    logic [63:0] q32_d[$];
    logic [63:0] q32_t[$];
    logic [63:0] q8_d[$];
    logic [63:0] q8_t[$];
    logic        acc32, emit32, acc8, emit8;
    logic [63:0] seen_d32, seen_t32, seen_d8, seen_t8;
    logic        stall8;
    logic [63:0] hold_d8, hold_t8;
    int          tagc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-by-bit definition of each mode on a w-bit operand.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int amt,
                                              input logic [2:0] op, input int w);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'd0:    r[i] = (i >= amt) ? d[i-amt] : 1'b0;
                3'd1:    r[i] = (i + amt < w) ? d[i+amt] : 1'b0;
                3'd2:    r[i] = (i + amt < w) ? d[i+amt] : d[w-1];
                3'd3:    r[i] = d[(i - amt + w) % w];
                3'd4:    r[i] = d[(i + amt) % w];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic tick32();
        @(negedge clock);
        emit32 = b32.out_valid && b32.out_ready;
        acc32  = b32.in_valid && b32.in_ready;
        if (emit32) begin
            seen_d32 = 64'(b32.out_data);
            seen_t32 = 64'(b32.out_tag);
            check_val("pending32", 64'(q32_d.size() != 0), 64'd1);
            if (q32_d.size() != 0) begin
                check_val("data32", seen_d32, q32_d.pop_front());
                check_val("tag32", seen_t32, q32_t.pop_front());
            end
        end
        if (acc32) begin
            q32_d.push_back(ref_shift(64'(b32.in_data), int'(b32.in_amt), b32.in_op, 32));
            q32_t.push_back(64'(b32.in_tag));
        end
        @(posedge clock);
        #1;
        check_val("flight32", 64'(b32.in_flight), 64'(q32_d.size()));
    endtask

    task automatic tick8();
        @(negedge clock);
        if (stall8) begin
            check_val("hold_valid8", 64'(b8.out_valid), 64'd1);
            check_val("hold_data8", 64'(b8.out_data), hold_d8);
            check_val("hold_tag8", 64'(b8.out_tag), hold_t8);
        end
        stall8  = b8.out_valid && !b8.out_ready;
        hold_d8 = 64'(b8.out_data);
        hold_t8 = 64'(b8.out_tag);
        emit8 = b8.out_valid && b8.out_ready;
        acc8  = b8.in_valid && b8.in_ready;
        if (emit8) begin
            seen_d8 = 64'(b8.out_data);
            seen_t8 = 64'(b8.out_tag);
            check_val("pending8", 64'(q8_d.size() != 0), 64'd1);
            if (q8_d.size() != 0) begin
                check_val("data8", seen_d8, q8_d.pop_front());
                check_val("tag8", seen_t8, q8_t.pop_front());
            end
        end
        if (acc8) begin
            q8_d.push_back(ref_shift(64'(b8.in_data), int'(b8.in_amt), b8.in_op, 8));
            q8_t.push_back(64'(b8.in_tag));
        end
        @(posedge clock);
        #1;
        check_val("flight8", 64'(b8.in_flight), 64'(q8_d.size()));
    endtask

    // One operation into an idle pipe with out_ready high; checks value and latency.
    task automatic run_one(input bit w8, input logic [2:0] op, input logic [31:0] d,
                           input logic [4:0] amt, input logic [31:0] exp, input string nm);
        int  n;
        bit  got;
        logic acc, emit;
        logic [63:0] seen;
        tagc++;
        if (w8) begin
            b8.out_ready = 1'b1; b8.in_valid = 1'b1; b8.in_op = op;
            b8.in_data = d[7:0]; b8.in_amt = amt[2:0]; b8.in_tag = 2'(tagc);
            tick8(); acc = acc8;
            b8.in_valid = 1'b0;
        end else begin
            b32.out_ready = 1'b1; b32.in_valid = 1'b1; b32.in_op = op;
            b32.in_data = d; b32.in_amt = amt; b32.in_tag = 4'(tagc);
            tick32(); acc = acc32;
            b32.in_valid = 1'b0;
        end
        check_val({nm, "_acc"}, 64'(acc), 64'd1);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            n++;
            if (w8) begin tick8();  emit = emit8;  seen = seen_d8;  end
            else    begin tick32(); emit = emit32; seen = seen_d32; end
            if (emit) begin
                got = 1'b1;
                check_val(nm, seen, 64'(exp));
                check_val({nm, "_lat"}, 64'(n), w8 ? 64'd3 : 64'd5);
            end
        end
        check_val({nm, "_seen"}, 64'(got), 64'd1);
    endtask

    logic [31:0] bp_d  [8];
    logic [4:0]  bp_a  [8];
    logic [2:0]  bp_o  [8];

    task automatic present_bp(input int idx);
        if (idx < 8) begin
            b32.in_valid = 1'b1; b32.in_data = bp_d[idx]; b32.in_amt = bp_a[idx];
            b32.in_op = bp_o[idx]; b32.in_tag = 4'(idx);
        end else begin
            b32.in_valid = 1'b0;
        end
    endtask

    initial begin
        int idx, emitted, last_c, n_acc, cyc;
        reset = 1'b1;
        stall8 = 1'b0;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.in_data = 32'd0;
        b32.in_amt = 5'd0; b32.in_op = 3'd0; b32.in_tag = 4'd0;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.in_data = 8'd0;
        b8.in_amt = 3'd0; b8.in_op = 3'd0; b8.in_tag = 2'd0;
        #2;
        check_val("rst_valid32", 64'(b32.out_valid), 64'd0);
        check_val("rst_ready32", 64'(b32.in_ready), 64'd0);
        check_val("rst_flight32", 64'(b32.in_flight), 64'd0);
        check_val("rst_data32", 64'(b32.out_data), 64'd0);
        check_val("rst_tag32", 64'(b32.out_tag), 64'd0);
        check_val("rst_valid8", 64'(b8.out_valid), 64'd0);
        check_val("rst_ready8", 64'(b8.in_ready), 64'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        run_one(1'b0, 3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra4");
        run_one(1'b0, 3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000, "srl4");
        run_one(1'b0, 3'b100, 32'h0000_0001, 5'd1,  32'h8000_0000, "ror1");
        run_one(1'b0, 3'b011, 32'h8000_0000, 5'd31, 32'h4000_0000, "rol31");
        run_one(1'b0, 3'b110, 32'h1234_5678, 5'd7,  32'h1234_5678, "pass7");
        run_one(1'b0, 3'b000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, "sll31");
        run_one(1'b0, 3'b001, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, "srl31");
        for (int op = 0; op < 8; op++) begin
            run_one(1'b0, 3'(op), 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, "amt0");
        end

        // Backpressure: 8 offered with out_ready low, then drained.
        for (int i = 0; i < 8; i++) begin
            bp_d[i] = $urandom; bp_a[i] = 5'($urandom); bp_o[i] = 3'($urandom_range(0, 7));
        end
        b32.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            present_bp(idx);
            tick32();
            if (acc32) idx++;
        end
        check_val("bp_accepted", 64'(idx), 64'd5);
        check_val("bp_ready", 64'(b32.in_ready), 64'd0);
        check_val("bp_flight", 64'(b32.in_flight), 64'd5);
        b32.out_ready = 1'b1;
        emitted = 0;
        last_c = 0;
        for (int c = 0; c < 40 && emitted < 8; c++) begin
            present_bp(idx);
            tick32();
            if (acc32) idx++;
            if (emit32) begin
                check_val("bp_tag", seen_t32, 64'(emitted));
                if (emitted > 0) check_val("bp_gap", 64'(c), 64'(last_c + 1));
                last_c = c;
                emitted++;
            end
        end
        b32.in_valid = 1'b0;
        check_val("bp_count", 64'(emitted), 64'd8);

        // Mid-flight asynchronous reset.
        b32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b32.in_valid = 1'b1; b32.in_data = $urandom; b32.in_amt = 5'($urandom);
            b32.in_op = 3'($urandom_range(0, 7)); b32.in_tag = 4'(i);
            tick32();
            check_val("pre_acc", 64'(acc32), 64'd1);
        end
        b32.in_valid = 1'b0;
        tick32();
        tick32();
        check_val("pre_rst_valid", 64'(b32.out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", 64'(b32.out_valid), 64'd0);
        check_val("mid_rst_flight", 64'(b32.in_flight), 64'd0);
        check_val("mid_rst_ready", 64'(b32.in_ready), 64'd0);
        check_val("mid_rst_data", 64'(b32.out_data), 64'd0);
        q32_d.delete();
        q32_t.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        run_one(1'b0, 3'b000, 32'h0000_0003, 5'd2, 32'h0000_000C, "post_rst");
        for (int i = 0; i < 8; i++) tick32();

        // Narrow instance: directed case then random traffic.
        stall8 = 1'b0;
        run_one(1'b1, 3'b011, 32'h0000_0081, 5'd1, 32'h0000_0003, "rol8");
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            b8.in_valid  = ($urandom_range(0, 3) != 0);
            b8.in_data   = 8'($urandom);
            b8.in_amt    = 3'($urandom);
            b8.in_op     = 3'($urandom_range(0, 7));
            b8.in_tag    = 2'($urandom);
            b8.out_ready = ($urandom_range(0, 3) != 0);
            tick8();
            if (acc8) n_acc++;
            cyc++;
        end
        check_val("rand_accepts", 64'(n_acc), 64'd10000);
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 20 && q8_d.size() != 0; i++) tick8();
        check_val("rand_drained", 64'(q8_d.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
